i2c_slave_device: RTL and testbench
===================================

Name: i2c_slave_device

Overview:
7-bit-address I2C target that sits on the same scl/sda bus as the codebase's I2C master and answers its transactions. It detects START/STOP, matches the address frame and ACKs it. On writes it delivers received bytes to local logic. On reads it fetches bytes from local logic and serialises them. scl is oversampled on the system clock; no clock stretching.

Parameters:
ADDRESS, 7'h42, 7-bit bus address this target responds to
SYNC_STAGES, 2, synchroniser depth on scl and sda inputs (>=2)

Ports:
clk  input  1  system clock; must run >= 8x scl frequency
rst  input  1  reset, asynchronous, active-high
scl  input  1  bus clock (target never drives it)
sda  inout  1  bus data; open-drain: driven 0 or released to 'bz, never driven 1
tx_data  input  8  byte to return on read; sampled one clk after tx_req
tx_req  output  1  one-clk pulse: supply next read byte on tx_data
rx_data  output  8  last byte written by master; held until next byte completes
rx_valid  output  1  one-clk pulse when rx_data updates
busy  output  1  high from address match until STOP/repeated START
start_det  output  1  one-clk pulse on every START (incl. repeated)
stop_det  output  1  one-clk pulse on every STOP

Behaviour:
- Reset (async): sda released, state IDLE, rx_data=0, rx_valid=0, tx_req=0, busy=0, start_det=0, stop_det=0, bit counter=0, shift regs=0.
- scl/sda pass through SYNC_STAGES flops, then a 1-flop edge detector. All bus events act SYNC_STAGES+1 clk after the pin edge.
- START: sda fall while synced scl=1. STOP: sda rise while scl=1. Both override any state and are checked before scl edges in the same clk.
- START from any state -> ADDR, counter=7, busy=0, sda released. STOP from any state -> IDLE, sda released, busy=0.
- Data sampled on scl rising edge, MSB first. sda changes only on scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift 8 bits {addr[6:0], rw}. On 8th rise: if addr==ADDRESS, set busy and latch rw. If rw=1, pulse tx_req on the same clk. Mismatch -> IGNORE.
- ADDR_ACK: on next scl fall, drive sda low. On the following fall, release. Then go to WR_BYTE (rw=0). For rw=1, go to RD_BYTE and put tx bit7 (latched 1 clk after tx_req) on sda in the same clk.
- WR_BYTE: 8 rises. On 8th rise, rx_data<=shift value and rx_valid pulses. Then go to WR_ACK: drive low on the next fall, release on the following fall, and return to WR_BYTE. No NACK on writes.
- RD_BYTE: drive the next bit on each fall. After the 8th bit's fall, release sda and go to RD_ACK.
- RD_ACK: sample master's sda on rise. 0 (ACK): pulse tx_req and go to RD_BYTE; the next fall drives bit7 of the new byte. 1 (NACK): go to IGNORE.
- IGNORE: sda released; wait for START/STOP.
- sda is driven low only when (ACK slot) or (RD_BYTE and current bit=0). Otherwise it is released.
- START/STOP mid-byte aborts: partial byte is discarded and rx_valid is not pulsed.
- Reset mid-transfer releases sda in the same instant (combinational from rst).
- Bus idle (scl=sda=1 after reset) produces no start/stop pulses.

Test Plan:
- Write 0x84 to 0x42: START, addr+W=8'h84, data 8'hA5, 8'h3C, STOP -> ACK low in 9th slot of all three bytes; rx_valid pulses twice with rx_data 8'hA5 then 8'h3C; stop_det pulses once; busy falls after STOP.
- Read: START, 8'h85, tx_data 8'h5A then 8'hC3; master ACKs byte 1, NACKs byte 2, then STOP -> sda shows 01011010 then 11000011; tx_req pulses twice; sda released after NACK.
- Address mismatch: START, 8'h20 (addr 0x10), one data byte -> sda never driven low; busy=0; rx_valid never pulses.
- Repeated START: write 8'h84, byte 8'h01, then Sr, 8'h85, read one byte with NACK -> rx_data=8'h01; start_det pulses twice; read byte returned correctly.
- Abort: STOP after 5 data bits, and separately rst asserted while driving ACK -> no rx_valid pulse; sda immediately 'bz; all outputs at reset values; next valid transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_device.sv
// ---------------------------------------------------------------------------
// i2c_slave_device
//
// 7-bit-address I2C target. It oversamples scl/sda on the system clock,
// detects START/STOP, matches and ACKs its address, hands written bytes to
// local logic and serialises read bytes fetched from local logic. It never
// drives scl, so it never stretches the clock.
//
// Parameters:
//   ADDRESS     - 7-bit bus address this target answers to
//   SYNC_STAGES - synchroniser depth on scl and sda (>= 2)
//
// Ports:
//   clk       in     system clock, at least 8x the scl frequency
//   rst       in     asynchronous active-high reset
//   scl       in     bus clock
//   sda       inout  bus data, open-drain (driven 0 or released to 'z)
//   tx_data   in     read byte, sampled one clk after tx_req
//   tx_req    out    one-clk pulse asking for the next read byte
//   rx_data   out    last byte written by the master
//   rx_valid  out    one-clk pulse when rx_data updates
//   busy      out    high from address match until STOP / repeated START
//   start_det out    one-clk pulse on every START (incl. repeated)
//   stop_det  out    one-clk pulse on every STOP
// ---------------------------------------------------------------------------
module i2c_slave_device #(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    // Synchroniser chains and the one-flop edge detector behind them.
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    // Protocol state.
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       rw_q, rw_d;
    logic       sda_low_q, sda_low_d;
    logic       ack_hold_q, ack_hold_d;
    logic       load_pending_q, load_pending_d;

    // Decoded bus events.
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_cond, stop_cond;
    logic [7:0] shift_in;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_cond = scl_s & ~sda_s & sda_prev_q;
    assign stop_cond  = scl_s & sda_s & ~sda_prev_q;
    assign shift_in   = {shift_q[6:0], sda_s};

    // Open-drain output. Gating with rst lets a reset let go of the bus at
    // once instead of waiting for the register to clear.
    assign sda = (sda_low_q && !rst) ? 1'b0 : 1'bz;

    assign tx_req    = tx_req_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

    // Shift the raw pins through the synchronisers and remember the
    // previous synchronised value for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Synchronisers reset to 1, matching an idle pulled-up bus, so that
    // coming out of reset on an idle bus never looks like a START or STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // Next-state logic. START and STOP are checked first so they override
    // whatever the byte engine was doing; a partially shifted byte is simply
    // dropped. bit_cnt counts down from 7 so a value of 0 marks the last bit.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        tx_shift_d     = tx_shift_q;
        rx_data_d      = rx_data_q;
        rw_d           = rw_q;
        busy_d         = busy_q;
        sda_low_d      = sda_low_q;
        ack_hold_d     = ack_hold_q;
        load_pending_d = load_pending_q;
        rx_valid_d     = 1'b0;
        tx_req_d       = 1'b0;
        start_det_d    = 1'b0;
        stop_det_d     = 1'b0;

        if (start_cond) begin
            state_d        = ADDR;
            bit_cnt_d      = 3'd7;
            shift_d        = '0;
            busy_d         = 1'b0;
            sda_low_d      = 1'b0;
            ack_hold_d     = 1'b0;
            load_pending_d = 1'b0;
            start_det_d    = 1'b1;
        end else if (stop_cond) begin
            state_d        = IDLE;
            bit_cnt_d      = 3'd0;
            shift_d        = '0;
            busy_d         = 1'b0;
            sda_low_d      = 1'b0;
            ack_hold_d     = 1'b0;
            load_pending_d = 1'b0;
            stop_det_d     = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            if (shift_in[7:1] == ADDRESS) begin
                                busy_d     = 1'b1;
                                rw_d       = shift_in[0];
                                tx_req_d   = shift_in[0];
                                ack_hold_d = 1'b0;
                                state_d    = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                // First fall opens the ACK slot, second fall closes it.
                // For a read the first data bit goes out on that same fall.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hold_q) begin
                            sda_low_d  = 1'b1;
                            ack_hold_d = 1'b1;
                        end else begin
                            ack_hold_d = 1'b0;
                            bit_cnt_d  = 3'd7;
                            if (rw_q) begin
                                state_d   = RD_BYTE;
                                sda_low_d = ~tx_shift_q[7];
                            end else begin
                                state_d   = WR_BYTE;
                                sda_low_d = 1'b0;
                                shift_d   = '0;
                            end
                        end
                    end
                end

                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            ack_hold_d = 1'b0;
                            state_d    = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                // Writes are always acknowledged.
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hold_q) begin
                            sda_low_d  = 1'b1;
                            ack_hold_d = 1'b1;
                        end else begin
                            ack_hold_d = 1'b0;
                            sda_low_d  = 1'b0;
                            bit_cnt_d  = 3'd7;
                            shift_d    = '0;
                            state_d    = WR_BYTE;
                        end
                    end
                end

                // After a master ACK we arrive here on an scl rise, so bit7
                // must wait for the next fall (load_pending) rather than
                // change sda while scl is high.
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (load_pending_q) begin
                            load_pending_d = 1'b0;
                            sda_low_d      = ~tx_shift_q[7];
                        end else if (bit_cnt_q == 3'd0) begin
                            sda_low_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            sda_low_d  = ~tx_shift_q[6];
                            bit_cnt_d  = bit_cnt_q - 3'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d       = 1'b1;
                            load_pending_d = 1'b1;
                            bit_cnt_d      = 3'd7;
                            state_d        = RD_BYTE;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end

                default: begin
                    sda_low_d = 1'b0;
                end
            endcase
        end

        // Local logic answers tx_req with a byte one clk later.
        if (tx_req_q) begin
            tx_shift_d = tx_data;
        end
    end

    // Protocol registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 3'd0;
            shift_q        <= '0;
            tx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_req_q       <= 1'b0;
            busy_q         <= 1'b0;
            start_det_q    <= 1'b0;
            stop_det_q     <= 1'b0;
            rw_q           <= 1'b0;
            sda_low_q      <= 1'b0;
            ack_hold_q     <= 1'b0;
            load_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            tx_shift_q     <= tx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            tx_req_q       <= tx_req_d;
            busy_q         <= busy_d;
            start_det_q    <= start_det_d;
            stop_det_q     <= stop_det_d;
            rw_q           <= rw_d;
            sda_low_q      <= sda_low_d;
            ack_hold_q     <= ack_hold_d;
            load_pending_q <= load_pending_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_device.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_device
//
// Directed bench for i2c_slave_device. A behavioural bus master drives scl
// and an open-drain sda; a negedge monitor counts DUT pulses, logs received
// bytes and answers tx_req from a per-test byte table.
// ---------------------------------------------------------------------------
module tb_i2c_slave_device;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       master_low;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_req, rx_valid, busy, start_det, stop_det;
    logic [7:0] rx_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int rx_cnt      = 0;
    int tx_cnt      = 0;
    int start_cnt   = 0;
    int stop_cnt    = 0;
    int dut_low_cnt = 0;
    logic [7:0] rx_log   [0:63];
    logic [7:0] tx_bytes [0:63];

    assign sda = master_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_device #(
        .ADDRESS     (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Monitor and read-data responder, sampling away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log[rx_cnt[5:0]] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_req === 1'b1) begin
            tx_data = tx_bytes[tx_cnt[5:0]];
            tx_cnt  = tx_cnt + 1;
        end
        if (start_det === 1'b1) start_cnt = start_cnt + 1;
        if (stop_det === 1'b1) stop_cnt = stop_cnt + 1;
        if (sda === 1'b0 && !master_low) dut_low_cnt = dut_low_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        master_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        seen = sda;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_start();
        master_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_stop();
        master_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic recv_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~give_ack, s);
    endtask

    // Reset values, then an idle bus must not produce START/STOP pulses.
    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; master_low = 1'b0;
        wait_clks(5);
        tests_run++; if (sda !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        tests_run++; if (tx_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (start_det !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_start_det: got %b expected 0", start_det); end
        tests_run++; if (stop_det !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stop_det: got %b expected 0", stop_det); end
        rst = 1'b0;
        wait_clks(30);
        tests_run++; if (start_cnt !== 0) begin tests_failed++; $display("[TB] FAIL idle_start: got %0d expected 0", start_cnt); end
        tests_run++; if (stop_cnt !== 0) begin tests_failed++; $display("[TB] FAIL idle_stop: got %0d expected 0", stop_cnt); end
    endtask

    task automatic test_write();
        int rx_base, start_base, stop_base;
        logic a0, a1, a2;
        logic busy_mid;
        rx_base = rx_cnt; start_base = start_cnt; stop_base = stop_cnt;
        bus_start();
        send_byte(8'h84, a0);
        busy_mid = busy;
        send_byte(8'hA5, a1);
        send_byte(8'h3C, a2);
        bus_stop();
        tests_run++; if (a0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_addr_ack: got %b expected 1", a0); end
        tests_run++; if (a1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_ack1: got %b expected 1", a1); end
        tests_run++; if (a2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_ack2: got %b expected 1", a2); end
        tests_run++; if (busy_mid !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_busy_mid: got %b expected 1", busy_mid); end
        tests_run++; if (rx_cnt - rx_base !== 2) begin tests_failed++; $display("[TB] FAIL write_rx_count: got %0d expected 2", rx_cnt - rx_base); end
        tests_run++; if (rx_log[6'(rx_base)] !== 8'hA5) begin tests_failed++; $display("[TB] FAIL write_byte1: got %h expected a5", rx_log[6'(rx_base)]); end
        tests_run++; if (rx_log[6'(rx_base + 1)] !== 8'h3C) begin tests_failed++; $display("[TB] FAIL write_byte2: got %h expected 3c", rx_log[6'(rx_base + 1)]); end
        tests_run++; if (rx_data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL write_rx_hold: got %h expected 3c", rx_data); end
        tests_run++; if (start_cnt - start_base !== 1) begin tests_failed++; $display("[TB] FAIL write_start_count: got %0d expected 1", start_cnt - start_base); end
        tests_run++; if (stop_cnt - stop_base !== 1) begin tests_failed++; $display("[TB] FAIL write_stop_count: got %0d expected 1", stop_cnt - stop_base); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        int tx_base, stop_base;
        logic a;
        logic [7:0] d0, d1;
        logic sda_after_nack;
        tx_base = tx_cnt; stop_base = stop_cnt;
        tx_bytes[6'(tx_cnt)]     = 8'h5A;
        tx_bytes[6'(tx_cnt + 1)] = 8'hC3;
        bus_start();
        send_byte(8'h85, a);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        sda_after_nack = sda;
        bus_stop();
        tests_run++; if (a !== 1'b1) begin tests_failed++; $display("[TB] FAIL read_addr_ack: got %b expected 1", a); end
        tests_run++; if (d0 !== 8'h5A) begin tests_failed++; $display("[TB] FAIL read_byte1: got %h expected 5a", d0); end
        tests_run++; if (d1 !== 8'hC3) begin tests_failed++; $display("[TB] FAIL read_byte2: got %h expected c3", d1); end
        tests_run++; if (tx_cnt - tx_base !== 2) begin tests_failed++; $display("[TB] FAIL read_tx_req_count: got %0d expected 2", tx_cnt - tx_base); end
        tests_run++; if (sda_after_nack !== 1'b1) begin tests_failed++; $display("[TB] FAIL read_release_after_nack: got %b expected 1", sda_after_nack); end
        tests_run++; if (stop_cnt - stop_base !== 1) begin tests_failed++; $display("[TB] FAIL read_stop_count: got %0d expected 1", stop_cnt - stop_base); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL read_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_addr_mismatch();
        int rx_base, low_base;
        logic a0, a1, busy_mid;
        rx_base = rx_cnt; low_base = dut_low_cnt;
        bus_start();
        send_byte(8'h20, a0);
        busy_mid = busy;
        send_byte(8'h3C, a1);
        bus_stop();
        tests_run++; if (a0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_addr_ack: got %b expected 0", a0); end
        tests_run++; if (a1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_data_ack: got %b expected 0", a1); end
        tests_run++; if (busy_mid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_busy: got %b expected 0", busy_mid); end
        tests_run++; if (dut_low_cnt - low_base !== 0) begin tests_failed++; $display("[TB] FAIL mismatch_sda_driven: got %0d expected 0", dut_low_cnt - low_base); end
        tests_run++; if (rx_cnt - rx_base !== 0) begin tests_failed++; $display("[TB] FAIL mismatch_rx_valid: got %0d expected 0", rx_cnt - rx_base); end
    endtask

    task automatic test_repeated_start();
        int rx_base, start_base, stop_base;
        logic a0, a1, a2;
        logic [7:0] d;
        rx_base = rx_cnt; start_base = start_cnt; stop_base = stop_cnt;
        tx_bytes[6'(tx_cnt)] = 8'h96;
        bus_start();
        send_byte(8'h84, a0);
        send_byte(8'h01, a1);
        bus_start();
        send_byte(8'h85, a2);
        recv_byte(1'b0, d);
        bus_stop();
        tests_run++; if ({a0, a1, a2} !== 3'b111) begin tests_failed++; $display("[TB] FAIL rs_acks: got %b expected 111", {a0, a1, a2}); end
        tests_run++; if (rx_data !== 8'h01) begin tests_failed++; $display("[TB] FAIL rs_rx_data: got %h expected 01", rx_data); end
        tests_run++; if (rx_cnt - rx_base !== 1) begin tests_failed++; $display("[TB] FAIL rs_rx_count: got %0d expected 1", rx_cnt - rx_base); end
        tests_run++; if (start_cnt - start_base !== 2) begin tests_failed++; $display("[TB] FAIL rs_start_count: got %0d expected 2", start_cnt - start_base); end
        tests_run++; if (d !== 8'h96) begin tests_failed++; $display("[TB] FAIL rs_read_byte: got %h expected 96", d); end
        tests_run++; if (stop_cnt - stop_base !== 1) begin tests_failed++; $display("[TB] FAIL rs_stop_count: got %0d expected 1", stop_cnt - stop_base); end
    endtask

    task automatic test_abort();
        int rx_base, stop_base;
        logic a, b, s;
        logic [7:0] addr_w;
        // STOP after five data bits: nothing delivered, old rx_data kept.
        rx_base = rx_cnt; stop_base = stop_cnt;
        bus_start();
        send_byte(8'h84, a);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s);
        clock_bit(1'b1, s); clock_bit(1'b0, s);
        bus_stop();
        tests_run++; if (a !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_addr_ack: got %b expected 1", a); end
        tests_run++; if (rx_cnt - rx_base !== 0) begin tests_failed++; $display("[TB] FAIL abort_rx_valid: got %0d expected 0", rx_cnt - rx_base); end
        tests_run++; if (rx_data !== 8'h01) begin tests_failed++; $display("[TB] FAIL abort_rx_hold: got %h expected 01", rx_data); end
        tests_run++; if (stop_cnt - stop_base !== 1) begin tests_failed++; $display("[TB] FAIL abort_stop_count: got %0d expected 1", stop_cnt - stop_base); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end

        // Reset while the DUT holds the address ACK low.
        rx_base = rx_cnt;
        addr_w = 8'h84;
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(addr_w[i], s);
        master_low = 1'b0;
        wait_clks(2);
        tests_run++; if (sda !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_ack_driven: got %b expected 0", sda); end
        rst = 1'b1;
        #1;
        tests_run++; if (sda !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_rst_release: got %b expected 1", sda); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL abort_rst_rx_data: got %h expected 00", rx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_rst_busy: got %b expected 0", busy); end
        tests_run++; if ({rx_valid, tx_req, start_det, stop_det} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL abort_rst_pulses: got %b expected 0000", {rx_valid, tx_req, start_det, stop_det}); end
        scl = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(20);

        // A fresh transaction after the reset must work normally.
        bus_start();
        send_byte(8'h84, a);
        send_byte(8'h77, b);
        bus_stop();
        tests_run++; if ({a, b} !== 2'b11) begin tests_failed++; $display("[TB] FAIL abort_recover_acks: got %b expected 11", {a, b}); end
        tests_run++; if (rx_data !== 8'h77) begin tests_failed++; $display("[TB] FAIL abort_recover_rx: got %h expected 77", rx_data); end
        tests_run++; if (rx_cnt - rx_base !== 1) begin tests_failed++; $display("[TB] FAIL abort_recover_count: got %0d expected 1", rx_cnt - rx_base); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_repeated_start();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
